// File: rtl/sram_req_ctrl.sv
// sram_req_ctrl: single-port SRAM front end. Accepts host reads/writes over a
// valid/ready request channel, returns read data over a valid/ready response
// channel, and runs a full-array clear sweep on request.
//
// Ports
//   CLK, RST_N              clock, asynchronous active-low reset
//   req_valid/req_ready     request handshake (ready is combinational)
//   req_we, req_addr,       request type (1 = write), word address, write data
//   req_wdata
//   resp_valid/resp_ready   read response handshake
//   resp_rdata              read data, held until consumed
//   clr_start               request a clear sweep (honoured only in IDLE)
//   clr_busy, clr_done      sweep in progress / one-cycle completion pulse
//   ADR, D, WE              SRAM address, write data, write enable (combinational)
//   Q                       SRAM read data, valid one cycle after the address edge
module sram_req_ctrl #(
  parameter int unsigned           ADDR_WIDTH = 8,
  parameter int unsigned           DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] CLR_VAL    = '0
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  input  logic                  clr_start,
  output logic                  clr_busy,
  output logic                  clr_done,
  output logic [ADDR_WIDTH-1:0] ADR,
  output logic [DATA_WIDTH-1:0] D,
  output logic                  WE,
  input  logic [DATA_WIDTH-1:0] Q
);

  localparam logic [ADDR_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    CLEAR   = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
  logic                    resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0]   resp_rdata_q, resp_rdata_d;
  logic                    clr_done_q, clr_done_d;
  logic                    req_en_q;
  logic                    resp_stall_c;
  logic                    accept_c;

  // Held low through reset and released on the first edge after RST_N rises,
  // so req_ready cannot assert while the block is still in reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      req_en_q <= 1'b0;
    end else begin
      req_en_q <= 1'b1;
    end
  end

  // A response that is presented but not consumed this cycle blocks new requests.
  assign resp_stall_c = resp_valid_q && !resp_ready;
  assign req_ready    = req_en_q && (state_q == IDLE) && !clr_start && !resp_stall_c;
  assign accept_c     = req_valid && req_ready;

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      clr_cnt_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      clr_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      clr_done_q   <= clr_done_d;
    end
  end

  // Next-state, response and SRAM-port logic.
  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    clr_done_d   = 1'b0;
    ADR          = '0;
    D            = '0;
    WE           = 1'b0;

    // Draining is independent of state, so a response stays consumable during CLEAR.
    if (resp_valid_q && resp_ready) begin
      resp_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        // clr_start wins over a simultaneous request (req_ready is already low).
        if (clr_start) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end else if (accept_c) begin
          ADR = req_addr;
          D   = req_wdata;
          WE  = req_we;
          if (!req_we) begin
            state_d = RD_WAIT;
          end
        end
      end

      RD_WAIT: begin
        // Q now holds the word addressed on the accept edge. Any earlier
        // response was drained on that same edge, so overwriting is safe.
        state_d      = IDLE;
        resp_valid_d = 1'b1;
        resp_rdata_d = Q;
      end

      CLEAR: begin
        ADR = clr_cnt_q;
        D   = CLR_VAL;
        WE  = 1'b1;
        // Stop at the last address rather than wrapping into a second sweep.
        if (clr_cnt_q == CNT_MAX) begin
          state_d    = IDLE;
          clr_done_d = 1'b1;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign clr_busy   = (state_q == CLEAR);
  assign clr_done   = clr_done_q;

endmodule

// File: doc/sram_req_ctrl.md
SRAM_REQ_CTRL -- requirements
Module: sram_req_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, SHALL set the SRAM word-address width; depth is 2**ADDR_WIDTH.
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the SRAM word width.
REQ-003 Parameter CLR_VAL, default 0, SHALL set the DATA_WIDTH-bit word written by the clear sweep.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 CLK  input  1  SHALL be the clock; all state updates on its rising edge.
REQ-006 RST_N  input  1  SHALL be the asynchronous active-low reset.
REQ-007 req_valid  input  1  SHALL signal that a host request is presented.
REQ-008 req_ready  output  1  SHALL signal that the block accepts the request this cycle.
REQ-009 req_we  input  1  SHALL mark the request as a write (1) or a read (0).
REQ-010 req_addr  input  ADDR_WIDTH  SHALL carry the request word address.
REQ-011 req_wdata  input  DATA_WIDTH  SHALL carry the write data.
REQ-012 resp_valid  output  1  SHALL signal that read data is presented.
REQ-013 resp_ready  input  1  SHALL signal that the host consumes the read data this cycle.
REQ-014 resp_rdata  output  DATA_WIDTH  SHALL carry the read data.
REQ-015 clr_start  input  1  SHALL request a full-array clear sweep.
REQ-016 clr_busy  output  1  SHALL be high while the sweep runs.
REQ-017 clr_done  output  1  SHALL pulse for one cycle when the sweep completes.
REQ-018 ADR  output  ADDR_WIDTH  SHALL drive the SRAM address.
REQ-019 D  output  DATA_WIDTH  SHALL drive the SRAM write data.
REQ-020 WE  output  1  SHALL drive the SRAM write enable, with a full-word mask.
REQ-021 Q  input  DATA_WIDTH  SHALL receive SRAM read data, valid one cycle after the address edge.

Function
REQ-022 The FSM SHALL have three states: IDLE, RD_WAIT and CLEAR.
REQ-023 Handshakes SHALL complete on an edge where valid && ready.
REQ-024 req_ready SHALL equal (state==IDLE) && !clr_start && !(resp_valid && !resp_ready).
REQ-025 ADR, D and WE SHALL be combinational and are defined as follows:
- Request accepted this cycle: ADR=req_addr, D=req_wdata, WE=req_we.
- In CLEAR: ADR=clr_cnt, D=CLR_VAL, WE=1.
- Otherwise: WE=0, ADR=0, D=0.
REQ-026 An accepted write SHALL complete in the accept cycle with no response, so back-to-back writes sustain one per cycle.
REQ-027 An accepted read SHALL move IDLE->RD_WAIT.
REQ-028 In RD_WAIT, at the next edge, resp_rdata SHALL load Q, resp_valid SHALL set and the FSM SHALL return to IDLE, giving a 2-edge latency from accept to resp_valid.
REQ-029 resp_valid and resp_rdata SHALL hold stable until resp_ready is high; resp_valid clears on that edge unless a new read response loads on the same edge.
REQ-030 A new read SHALL be accepted in the same cycle resp_ready drains the pending response, sustaining one read per two cycles.
REQ-031 clr_start in IDLE SHALL win over req_valid: no request is accepted, clr_cnt is loaded with 0 and the FSM moves to CLEAR.
REQ-032 clr_start outside IDLE SHALL be ignored and SHALL not be latched.
REQ-033 CLEAR SHALL write every address from 0 to 2**ADDR_WIDTH-1 in 2**ADDR_WIDTH consecutive cycles, with clr_busy high throughout.
REQ-034 On the edge where clr_cnt equals its maximum value, the FSM SHALL return to IDLE and clr_done SHALL be high for the following single cycle.
REQ-035 clr_cnt SHALL not wrap into a second sweep.
REQ-036 A pending resp_valid SHALL remain drainable during CLEAR.

Reset
REQ-037 On RST_N low, the block SHALL asynchronously set:
- state=IDLE and clr_cnt=0;
- resp_valid=0, resp_rdata=0;
- clr_busy=0, clr_done=0;
- WE=0, ADR=0, D=0.
REQ-038 Reset during CLEAR SHALL abort the sweep, leave the array partially cleared and not pulse clr_done.
REQ-039 Reset during RD_WAIT SHALL discard the read without producing a response.
REQ-040 req_ready SHALL be 0 while RST_N is low and SHALL first assert in the cycle after release.

Verification
REQ-041 Write addr 0x12 data 0xA5, then read 0x12 with resp_ready=1 -> resp_valid high 2 edges after read accept, resp_rdata=0xA5.
REQ-042 Four back-to-back writes to 0x00-0x03 -> WE=1 on 4 consecutive cycles, req_ready continuously 1.
REQ-043 Read response with resp_ready held 0 for 5 cycles -> resp_rdata stable, req_ready=0, no SRAM access until drain.
REQ-044 clr_start with req_valid also high -> request not accepted, clr_busy for 256 cycles, clr_done one cycle, then read 0xFF returns CLR_VAL=0x00.
REQ-045 Assert RST_N low at clear cycle 100 -> all outputs at reset values, no clr_done, address 0xC8 retains its prior data.
